// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues synchronous imem reads and buffers {word, pc} pairs in a DEPTH-entry FIFO.
// First word is valid 2 cycles after reset release (3 after redirect); issue stalls once FIFO + in-flight reach DEPTH.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [31:0]   fifo_word_q [DEPTH];
  logic [31:0]   fifo_word_d [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_pc_d   [DEPTH];
  logic          push;
  logic          pop;
  logic          redirect_pc_unused;

  always_comb begin
    // Credit only counts registered state, so a pop frees a slot one cycle later.
    mem_req     = !reset && !redirect && ((count_q + CW'(inflight_q)) < DEPTH_C);
    mem_addr    = fetch_pc_q;
    instr_valid = (count_q != '0);
    instruction = instr_valid ? fifo_word_q[rd_ptr_q] : 32'h0000_0000;
    instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : last_pc_q;

    push = inflight_q && !drop_q && !redirect;
    pop  = instr_valid && instr_ready && !redirect;

    redirect_pc_unused = ^redirect_pc[1:0];

    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (mem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    inflight_d    = mem_req;
    inflight_pc_d = fetch_pc_q;
    drop_d        = mem_req && redirect;
    last_pc_d     = instr_pc;

    fifo_word_d = fifo_word_q;
    fifo_pc_d   = fifo_pc_q;
    if (push) begin
      fifo_word_d[wr_ptr_q] = mem_rdata;
      fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
    end

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      drop_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      last_pc_q     <= RESET_PC;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      last_pc_q     <= last_pc_d;
    end
  end

  // Storage is pure datapath; count gates visibility, so no reset is needed.
  always_ff @(posedge clock) begin
    fifo_word_q <= fifo_word_d;
    fifo_pc_q   <= fifo_pc_d;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: expected pcs are queued with the stimulus, negedge monitors pop and compare on each handshake.
module tb_instr_fetch_unit;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, redirect, instr_ready;
  logic [31:0] redirect_pc;
  logic        mem_req, instr_valid;
  logic [31:0] mem_addr, mem_rdata, instruction, instr_pc;

  logic        rst_w, ready_w, mem_req_w, instr_valid_w;
  logic [31:0] mem_addr_w, mem_rdata_w, instruction_w, instr_pc_w;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] mon_e, mon_w_e;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clock(clock), .reset(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
    .clock(clock), .reset(rst_w), .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
    .instruction(instruction_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(ready_w), .redirect(1'b0), .redirect_pc(32'h0000_0000)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // Synchronous instruction memory: data one cycle after the request, garbage otherwise.
  always @(posedge clock) begin
    mem_rdata   <= mem_req   ? mem_word(mem_addr)   : 32'hDEAD_BEEF;
    mem_rdata_w <= mem_req_w ? mem_word(mem_addr_w) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!rst && !redirect && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_word: got pc %h expected no delivery", instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", instr_pc, mon_e);
        check("sb_word", instruction, mem_word(mon_e));
      end
    end
  end

  always @(negedge clock) begin
    if (!rst_w && instr_valid_w && ready_w) begin
      if (exp_w_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_word_wrap: got pc %h expected no delivery", instr_pc_w);
      end else begin
        mon_w_e = exp_w_q.pop_front();
        check("sb_wrap_pc", instr_pc_w, mon_w_e);
        check("sb_wrap_word", instruction_w, mem_word(mon_w_e));
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) next();
  endtask

  task automatic drain(input string name, input bit wrap);
    int n = 0;
    while ((wrap ? exp_w_q.size() : exp_q.size()) != 0 && n < 60) begin
      next();
      n++;
    end
    total++;
    if ((wrap ? exp_w_q.size() : exp_q.size()) != 0) begin
      bad++;
      $display("FAIL %s: got %0d undelivered words expected 0", name,
               wrap ? exp_w_q.size() : exp_q.size());
      exp_q.delete();
      exp_w_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst_w = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b1; ready_w = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_w_instr_pc", instr_pc_w, 32'hFFFF_FFF8);
    check("rst_w_mem_addr", mem_addr_w, 32'hFFFF_FFF8);

    // PC wrap through 2^32
    exp_w_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    next();
    rst_w = 1'b0;
    drain("wrap_stream", 1'b1);
    ready_w = 1'b0;

    // Streaming, then redirect to 0x103 with a response due and a pop offered
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    next();
    rst = 1'b0; cyc = 0;
    @(negedge clock);
    check("c0_mem_req", 32'(mem_req), 32'd1);
    check("c0_mem_addr", mem_addr, 32'h0);
    check("c0_valid", 32'(instr_valid), 32'd0);
    next(); @(negedge clock);
    check("c1_valid", 32'(instr_valid), 32'd0);
    check("c1_mem_addr", mem_addr, 32'h4);
    next(); @(negedge clock);
    check("c2_valid", 32'(instr_valid), 32'd1);
    goto(7);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clock);
    check("rd_mem_req", 32'(mem_req), 32'd0);
    goto(8);
    redirect = 1'b0;
    @(negedge clock);
    check("rd1_valid", 32'(instr_valid), 32'd0);
    check("rd1_mem_addr", mem_addr, 32'h100);
    check("rd1_mem_req", 32'(mem_req), 32'd1);
    check("rd1_instruction", instruction, 32'h0);
    check("rd1_instr_pc_hold", instr_pc, 32'h14);
    goto(10); @(negedge clock);
    check("rd3_valid", 32'(instr_valid), 32'd1);

    // Back-to-back redirects coinciding with a pop: last target wins
    goto(14);
    check("pre_b2b_pending", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h300 + 32'(i * 4));
    redirect = 1'b1; redirect_pc = 32'h200;
    goto(15);
    redirect_pc = 32'h300;
    goto(16);
    redirect = 1'b0;
    @(negedge clock);
    check("b2b_mem_addr", mem_addr, 32'h300);
    check("b2b_mem_req", 32'(mem_req), 32'd1);
    drain("redirect_stream", 1'b0);
    instr_ready = 1'b0;

    // Back-pressure from reset
    rst = 1'b1;
    next(); next();
    for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
    rst = 1'b0; cyc = 0;
    for (int c = 4; c <= 8; c++) begin
      goto(c);
      @(negedge clock);
      check("bp_mem_req", 32'(mem_req), 32'd0);
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_head_pc", instr_pc, 32'h0);
      check("bp_head_word", instruction, mem_word(32'h0));
    end
    check("bp_mem_addr", mem_addr, 32'h10);
    goto(9);
    instr_ready = 1'b1;
    drain("bp_release", 1'b0);
    instr_ready = 1'b0;

    // Mid-run reset with three words buffered
    rst = 1'b1;
    next(); next();
    rst = 1'b0; cyc = 0;
    goto(4);
    @(negedge clock);
    check("mr_pre_valid", 32'(instr_valid), 32'd1);
    check("mr_pre_pc", instr_pc, 32'h0);
    next();
    rst = 1'b1;
    @(negedge clock);
    check("mr_rst_mem_req", 32'(mem_req), 32'd0);
    next();
    rst = 1'b0; cyc = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    @(negedge clock);
    check("mr_c0_valid", 32'(instr_valid), 32'd0);
    check("mr_c0_mem_addr", mem_addr, 32'h0);
    check("mr_c0_mem_req", 32'(mem_req), 32'd1);
    next(); @(negedge clock);
    check("mr_c1_valid", 32'(instr_valid), 32'd0);
    next(); @(negedge clock);
    check("mr_c2_valid", 32'(instr_valid), 32'd1);
    check("mr_c2_pc", instr_pc, 32'h0);
    goto(3);
    instr_ready = 1'b1;
    drain("mr_stream", 1'b0);
    instr_ready = 1'b0;
    next(); next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
